// File: rtl/joy_spi_master_if.sv
// Bus bundle for the joystick SPI master: request/data handshake plus the SPI pins.
interface joy_spi_master_if;
    logic       getByte;
    logic [7:0] DIN;
    logic       MISO;
    logic       SCLK;
    logic       MOSI;
    logic       BUSY;
    logic [7:0] RxData;

    modport master (input getByte, DIN, MISO, output SCLK, MOSI, BUSY, RxData);
    modport slave  (output getByte, DIN, MISO, input SCLK, MOSI, BUSY, RxData);
endinterface

// File: rtl/joy_spi_master.sv
// Single-byte SPI mode-0 master for a joystick peripheral, with an inter-byte idle gap.
// Optional feature macro JOY_SPI_LOOPBACK_EN: receive path samples internal MOSI instead of MISO.
//
// state | meaning
// IDLE  | waiting for getByte, SCLK low, BUSY low
// SHIFT | 8 SCLK periods, MOSI out on falling, MISO in on rising
// GAP   | SCLK held low for BYTE_GAP cycles before BUSY drops
module joy_spi_master #(
    parameter int CLK_DIV  = 50,
    parameter int BYTE_GAP = 500
) (
    input logic              CLK,
    input logic              RST,
    joy_spi_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [9:0]  DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = (BYTE_GAP > 0) ? 16'(BYTE_GAP - 1) : 16'd0;

    state_t      state;
    logic [9:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] gap_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [7:0]  rx_data_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        busy_q;
    logic        rx_bit;

`ifdef JOY_SPI_LOOPBACK_EN
    assign rx_bit = mosi_q;
`else
    assign rx_bit = bus.MISO;
`endif

    assign bus.SCLK   = sclk_q;
    assign bus.MOSI   = mosi_q;
    assign bus.BUSY   = busy_q;
    assign bus.RxData = rx_data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.getByte) begin
                        busy_q  <= 1'b1;
                        tx_sr   <= bus.DIN;
                        mosi_q  <= bus.DIN[7];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        sclk_q  <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk_q  <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_sr <= {rx_sr[6:0], rx_bit};
                        end else if (bit_cnt == 4'd7) begin
                            // 8th falling edge: bit count parks at 8, line goes quiet
                            bit_cnt <= 4'd8;
                            mosi_q  <= 1'b0;
                            if (BYTE_GAP == 0) begin
                                rx_data_q <= rx_sr;
                                busy_q    <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                gap_cnt <= GAP_LOAD;
                                state   <= GAP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx_sr   <= {tx_sr[6:0], 1'b0};
                            mosi_q  <= tx_sr[6];
                        end
                    end else begin
                        div_cnt <= div_cnt + 10'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) begin
                        rx_data_q <= rx_sr;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joy_spi_master.sv
// Self-checking bench: two instances (CLK_DIV=4/BYTE_GAP=8 and CLK_DIV=1/BYTE_GAP=0) with behavioural SPI slaves.
module tb_joy_spi_master;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    joy_spi_master_if bus_a ();
    joy_spi_master_if bus_b ();

    joy_spi_master #(.CLK_DIV(4), .BYTE_GAP(8)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    joy_spi_master #(.CLK_DIV(1), .BYTE_GAP(0)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    // Slave models: bit index = SCLK falling edges since BUSY rose
    logic [7:0] slave_a = 8'h00;
    logic [7:0] slave_b = 8'h00;
    int fall_a = 0, base_a = 0, idx_a;
    int fall_b = 0, base_b = 0, idx_b;

    always @(negedge bus_a.SCLK) fall_a++;
    always @(posedge bus_a.BUSY) base_a = fall_a;
    always @(negedge bus_b.SCLK) fall_b++;
    always @(posedge bus_b.BUSY) base_b = fall_b;

    always_comb begin
        idx_a = fall_a - base_a;
        bus_a.MISO = (idx_a >= 0 && idx_a < 8) ? slave_a[7 - idx_a] : 1'b0;
    end
    always_comb begin
        idx_b = fall_b - base_b;
        bus_b.MISO = (idx_b >= 0 && idx_b < 8) ? slave_b[7 - idx_b] : 1'b0;
    end

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    function automatic logic [7:0] exp_rx(input logic [7:0] din, input logic [7:0] slave);
`ifdef JOY_SPI_LOOPBACK_EN
        return din;
`else
        return slave;
`endif
    endfunction

    // Observe one transfer on the selected instance until BUSY falls; optional mid-transfer poke of getByte/DIN.
    task automatic watch(input bit sel, input int poke_at, input int div,
                         output int busy_cycles, output int lead_idle, output int pulses,
                         output int bad_phase, output logic [7:0] mosi_bits,
                         output logic [7:0] rx, output bit timeout);
        logic s, prev_s, b;
        int hi, lo;
        bit done;
        busy_cycles = 0; lead_idle = 0; pulses = 0; bad_phase = 0;
        mosi_bits = '0; rx = '0; timeout = 1'b1;
        prev_s = 1'b0; hi = 0; lo = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            s = sel ? bus_b.SCLK : bus_a.SCLK;
            b = sel ? bus_b.BUSY : bus_a.BUSY;
            if (!b) begin
                if (busy_cycles > 0) begin
                    done = 1'b1;
                    timeout = 1'b0;
                    rx = sel ? bus_b.RxData : bus_a.RxData;
                end else begin
                    lead_idle++;
                end
            end else begin
                busy_cycles++;
                if (busy_cycles == poke_at) begin
                    if (sel) begin bus_b.getByte = 1'b1; bus_b.DIN = 8'hFF; end
                    else     begin bus_a.getByte = 1'b1; bus_a.DIN = 8'hFF; end
                end
                if (poke_at > 0 && busy_cycles == poke_at + 1) begin
                    if (sel) bus_b.getByte = 1'b0;
                    else     bus_a.getByte = 1'b0;
                end
                if (s && !prev_s) begin
                    pulses++;
                    mosi_bits = {mosi_bits[6:0], sel ? bus_b.MOSI : bus_a.MOSI};
                    if (lo != div) bad_phase++;
                    hi = 1;
                end else if (s) begin
                    hi++;
                end else if (prev_s) begin
                    if (hi != div) bad_phase++;
                    lo = 1;
                end else begin
                    lo++;
                end
                prev_s = s;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.getByte = 1'b1; bus_a.DIN = 8'hA5;
        bus_b.getByte = 1'b1; bus_b.DIN = 8'h5A;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b want 0", bus_a.BUSY); end
        checks++; if (bus_a.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk_a: got %b want 0", bus_a.SCLK); end
        checks++; if (bus_a.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi_a: got %b want 0", bus_a.MOSI); end
        checks++; if (bus_a.RxData !== 8'h00) begin errors++; $display("FAIL reset_rx_a: got %h want 00", bus_a.RxData); end
        checks++; if (bus_b.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", bus_b.BUSY); end
        checks++; if (bus_b.RxData !== 8'h00) begin errors++; $display("FAIL reset_rx_b: got %h want 00", bus_b.RxData); end
        bus_a.getByte = 1'b0;
        bus_b.getByte = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int bc, li, pu, bp;
        logic [7:0] mb, rx, e;
        bit to;
        slave_a = 8'h3C;
        q_a.push_back(exp_rx(8'hA5, 8'h3C));
        bus_a.DIN = 8'hA5;
        bus_a.getByte = 1'b1;
        @(posedge clk);
        #1 bus_a.getByte = 1'b0;
        watch(1'b0, 0, 4, bc, li, pu, bp, mb, rx, to);
        e = q_a.pop_front();
        checks++; if (to) begin errors++; $display("FAIL single_timeout: BUSY never fell"); end
        checks++; if (bc != 72) begin errors++; $display("FAIL single_busy_len: got %0d want 72", bc); end
        checks++; if (pu != 8) begin errors++; $display("FAIL single_sclk_pulses: got %0d want 8", pu); end
        checks++; if (bp != 0) begin errors++; $display("FAIL single_sclk_phase: got %0d bad phases want 0", bp); end
        checks++; if (mb !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h want a5", mb); end
        checks++; if (rx !== e) begin errors++; $display("FAIL single_rx: got %h want %h", rx, e); end
        repeat (5) @(negedge clk);
        checks++; if (bus_a.RxData !== e) begin errors++; $display("FAIL single_rx_hold: got %h want %h", bus_a.RxData, e); end
    endtask

    task automatic test_back_to_back();
        int bc, li, pu, bp;
        logic [7:0] mb, rx, e, din;
        bit to;
        for (int i = 0; i < 5; i++) begin
            din = 8'(8'h11 * (i + 1));
            slave_a = 8'(i + 1);
            bus_a.DIN = din;
            bus_a.getByte = 1'b1;
            q_a.push_back(exp_rx(din, 8'(i + 1)));
            watch(1'b0, 0, 4, bc, li, pu, bp, mb, rx, to);
            if (i == 4) bus_a.getByte = 1'b0;
            e = q_a.pop_front();
            checks++; if (to) begin errors++; $display("FAIL b2b_timeout[%0d]: BUSY never fell", i); end
            checks++; if (bc != 72) begin errors++; $display("FAIL b2b_busy_len[%0d]: got %0d want 72", i, bc); end
            if (i > 0) begin
                checks++; if (li != 0) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d extra idle cycles want 0", i, li); end
            end
            checks++; if (mb !== din) begin errors++; $display("FAIL b2b_mosi[%0d]: got %h want %h", i, mb, din); end
            checks++; if (rx !== e) begin errors++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx, e); end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus_a.BUSY !== 1'b0) begin errors++; $display("FAIL b2b_no_sixth: got BUSY=%b want 0", bus_a.BUSY); end
    endtask

    task automatic test_reset_mid();
        int rises, bc, li, pu, bp;
        logic prev_s;
        logic [7:0] mb, rx, e;
        bit to;
        rises = 0; prev_s = 1'b0;
        slave_a = 8'h0F;
        bus_a.DIN = 8'hF0;
        bus_a.getByte = 1'b1;
        @(posedge clk);
        #1 bus_a.getByte = 1'b0;
        for (int c = 0; c < 200 && rises < 3; c++) begin
            @(negedge clk);
            if (bus_a.SCLK && !prev_s) rises++;
            prev_s = bus_a.SCLK;
        end
        checks++; if (rises != 3) begin errors++; $display("FAIL rstmid_rises: got %0d want 3", rises); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.SCLK !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", bus_a.SCLK); end
        checks++; if (bus_a.BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus_a.BUSY); end
        checks++; if (bus_a.RxData !== 8'h00) begin errors++; $display("FAIL rstmid_rx: got %h want 00", bus_a.RxData); end
        rst = 1'b0;
        @(negedge clk);
        slave_a = 8'h69;
        bus_a.DIN = 8'h96;
        q_a.push_back(exp_rx(8'h96, 8'h69));
        bus_a.getByte = 1'b1;
        @(posedge clk);
        #1 bus_a.getByte = 1'b0;
        watch(1'b0, 0, 4, bc, li, pu, bp, mb, rx, to);
        e = q_a.pop_front();
        checks++; if (to || bc != 72) begin errors++; $display("FAIL rstmid_after_len: got %0d want 72", bc); end
        checks++; if (rx !== e) begin errors++; $display("FAIL rstmid_after_rx: got %h want %h", rx, e); end
    endtask

    task automatic test_ignored_inputs();
        int bc, li, pu, bp;
        logic [7:0] mb, rx, e;
        bit to;
        slave_a = 8'hC3;
        bus_a.DIN = 8'h66;
        q_a.push_back(exp_rx(8'h66, 8'hC3));
        bus_a.getByte = 1'b1;
        @(posedge clk);
        #1 bus_a.getByte = 1'b0;
        watch(1'b0, 10, 4, bc, li, pu, bp, mb, rx, to);
        e = q_a.pop_front();
        checks++; if (to || bc != 72) begin errors++; $display("FAIL ignore_busy_len: got %0d want 72", bc); end
        checks++; if (mb !== 8'h66) begin errors++; $display("FAIL ignore_mosi: got %h want 66", mb); end
        checks++; if (rx !== e) begin errors++; $display("FAIL ignore_rx: got %h want %h", rx, e); end
        repeat (4) @(negedge clk);
        checks++; if (bus_a.BUSY !== 1'b0) begin errors++; $display("FAIL ignore_extra_xfer: got BUSY=%b want 0", bus_a.BUSY); end
    endtask

    task automatic test_edge_params();
        int bc, li, pu, bp;
        logic [7:0] mb, rx, e;
        bit to;
        slave_b = 8'h81;
        bus_b.DIN = 8'h7E;
        q_b.push_back(exp_rx(8'h7E, 8'h81));
        bus_b.getByte = 1'b1;
        @(posedge clk);
        #1 bus_b.getByte = 1'b0;
        watch(1'b1, 0, 1, bc, li, pu, bp, mb, rx, to);
        e = q_b.pop_front();
        checks++; if (to) begin errors++; $display("FAIL edge_timeout: BUSY never fell"); end
        checks++; if (bc != 16) begin errors++; $display("FAIL edge_busy_len: got %0d want 16", bc); end
        checks++; if (pu != 8) begin errors++; $display("FAIL edge_sclk_pulses: got %0d want 8", pu); end
        checks++; if (bp != 0) begin errors++; $display("FAIL edge_sclk_phase: got %0d bad phases want 0", bp); end
        checks++; if (mb !== 8'h7E) begin errors++; $display("FAIL edge_mosi: got %h want 7e", mb); end
        checks++; if (rx !== e) begin errors++; $display("FAIL edge_rx: got %h want %h", rx, e); end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.getByte = 1'b0; bus_a.DIN = 8'h00;
        bus_b.getByte = 1'b0; bus_b.DIN = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_ignored_inputs();
        test_edge_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joy_spi_master.md
JOY_SPI_MASTER -- requirements
Module: joy_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 50, SCLK half-period in CLK cycles; legal range 1..1023.
REQ-002 Parameter BYTE_GAP, default 500, idle CLK cycles appended after the 8th bit before BUSY falls; legal range 0..65535.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 getByte  input  1  transfer request, level-sampled in IDLE.
REQ-006 DIN  input  8  byte to transmit, MSB first.
REQ-007 MISO  input  1  serial data from the joystick peripheral.
REQ-008 SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-009 MOSI  output  1  serial data to the peripheral.
REQ-010 BUSY  output  1  high for the entire transfer, including the gap.
REQ-011 RxData  output  8  last received byte, MSB first.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-013 In IDLE with getByte=1 at a rising edge, the block SHALL, at that edge, set BUSY=1, latch DIN into the TX shift register, drive MOSI=DIN[7], clear the bit counter and divider, and enter SHIFT.
REQ-014 In SHIFT, SCLK SHALL alternate low/high phases of exactly CLK_DIV cycles each, starting low, for 8 full periods (16*CLK_DIV cycles).
REQ-015 On each SCLK rising transition the block SHALL shift MISO into the LSB of the RX shift register.
REQ-016 On each SCLK falling transition except the 8th, MOSI SHALL advance to the next TX bit; after the 8th, MOSI SHALL go to 0.
REQ-017 After the 8th falling transition, SCLK SHALL remain low and the block SHALL enter GAP for exactly BYTE_GAP cycles (skipped when BYTE_GAP=0).
REQ-018 At the edge leaving GAP (or SHIFT when BYTE_GAP=0), the block SHALL copy the RX shift register to RxData, clear BUSY and enter IDLE at the same edge.
REQ-019 BUSY SHALL be high for exactly 16*CLK_DIV+BYTE_GAP consecutive cycles per transfer.
REQ-020 RxData SHALL hold stable from BUSY falling until the next transfer completes.
REQ-021 getByte and DIN SHALL be ignored while BUSY=1; DIN changes mid-transfer SHALL not affect MOSI.
REQ-022 getByte still high in IDLE after completion SHALL start a new transfer on the next edge (back-to-back; BUSY low for 1 cycle).
REQ-023 The divider and bit counter SHALL NOT wrap into a 9th bit; the bit count SHALL saturate at 8 on exit from SHIFT.

Reset
REQ-024 With RST=1 at a rising edge, state SHALL become IDLE, SCLK=0, MOSI=0, BUSY=0, RxData=8'h00, and all counters and shift registers SHALL clear, including mid-transfer (abort with no RxData update).
REQ-025 RST SHALL take priority over getByte in the same cycle.

Configuration
REQ-026 Macro JOY_SPI_LOOPBACK_EN, when defined, SHALL route the internal MOSI value to the receive path in place of the MISO pin (MISO ignored) while keeping MOSI and SCLK pin behaviour unchanged.
REQ-027 Without JOY_SPI_LOOPBACK_EN, the receive path SHALL sample the MISO pin only, and no loopback logic SHALL be synthesised.

Verification (CLK_DIV=4, BYTE_GAP=8 unless stated)
REQ-028 Single byte: DIN=8'hA5 and getByte for 1 cycle, slave returns 8'h3C -> BUSY high for exactly 72 cycles, 8 SCLK pulses of 4 high/4 low cycles, MOSI bits 1,0,1,0,0,1,0,1, RxData=8'h3C at the BUSY falling edge.
REQ-029 Five back-to-back requests (joystick packet), slave bytes 8'h01..8'h05 -> five BUSY windows each 72 cycles separated by exactly 1 low cycle; the RxData sequence is 01,02,03,04,05.
REQ-030 Reset mid-transfer: assert RST after the 3rd SCLK rising edge -> next cycle SCLK=0, BUSY=0, RxData=8'h00; a subsequent request completes normally.
REQ-031 Ignored inputs: pulse getByte and change DIN to 8'hFF during SHIFT -> MOSI still carries the original byte, with no extra transfer.
REQ-032 Edge parameters: CLK_DIV=1, BYTE_GAP=0, slave 8'h81 -> BUSY high for 16 cycles, RxData=8'h81.
REQ-033 With JOY_SPI_LOOPBACK_EN defined, MISO tied to 1, DIN=8'h5A -> RxData=8'h5A.
